mips_pipeline_processor: RTL and testbench



---
 rtl/mips_pipeline_processor.sv | 229 ++++++++++++++++++++++
 tb/tb_mips_pipeline_processor.sv | 117 +++++++++++
 2 files changed

// File: rtl/mips_pipeline_processor.sv
// Five-stage MIPS-subset core: byte-loadable imem, 32x32 regfile, 64-word dmem.
// EX operands forward from EX/MEM then MEM/WB; load-use stalls; beq resolves in EX.
module mips_pipeline_processor (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  write_data,
  input  logic [31:0] write_address,
  input  logic        We,
  input  logic        pc_enable,
  output logic [31:0] pc_output,
  output logic [31:0] ALU_Result,
  output logic [31:0] Mem_out
);

  typedef enum logic [2:0] {ALU_NOP, ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT} alu_op_e;

  typedef struct packed {
    logic    reg_write;
    logic    mem_read;
    logic    mem_write;
    logic    branch;
    logic    alu_src;
    alu_op_e alu_op;
  } ctrl_t;

  typedef struct packed {
    logic [7:0]  pc;
    logic [31:0] instr;
  } if_id_t;

  typedef struct packed {
    ctrl_t       ctrl;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  dest;
    logic [7:0]  pc;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] imm;
  } id_ex_t;

  typedef struct packed {
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic [4:0]  dest;
    logic [31:0] alu;
    logic [31:0] store;
  } ex_mem_t;

  typedef struct packed {
    logic        reg_write;
    logic        mem_read;
    logic [4:0]  dest;
    logic [31:0] alu;
    logic [31:0] mem_data;
  } mem_wb_t;

  logic [7:0]  imem [256];
  logic [31:0] dmem [64];
  logic [31:0] rf   [32];

  logic [7:0] pc;
  if_id_t     if_id;
  id_ex_t     id_ex, id_dec;
  ex_mem_t    ex_mem;
  mem_wb_t    mem_wb;

  // Host program load runs regardless of reset or run enable.
  always_ff @(posedge clk)
    if (We) imem[write_address[7:0]] <= write_data;

  // ---------------- IF ----------------
  logic [31:0] fetch_instr;
  assign fetch_instr = {imem[pc], imem[pc + 8'd1], imem[pc + 8'd2], imem[pc + 8'd3]};

  // ---------------- ID ----------------
  logic [5:0]  op, funct;
  logic [4:0]  rs, rt, rd, shamt;
  logic [31:0] wb_data;
  logic        wb_en;

  assign op    = if_id.instr[31:26];
  assign rs    = if_id.instr[25:21];
  assign rt    = if_id.instr[20:16];
  assign rd    = if_id.instr[15:11];
  assign shamt = if_id.instr[10:6];
  assign funct = if_id.instr[5:0];

  assign wb_data = mem_wb.mem_read ? mem_wb.mem_data : mem_wb.alu;
  assign wb_en   = mem_wb.reg_write && (mem_wb.dest != 5'd0);

  function automatic logic [31:0] rf_read(input logic [4:0] r);
    if (r == 5'd0)                    return '0;
    else if (wb_en && mem_wb.dest == r) return wb_data;
    else                              return rf[r];
  endfunction

  always_comb begin
    id_dec      = '0;
    id_dec.rs   = rs;
    id_dec.rt   = rt;
    id_dec.pc   = if_id.pc;
    id_dec.a    = rf_read(rs);
    id_dec.b    = rf_read(rt);
    id_dec.imm  = {{16{if_id.instr[15]}}, if_id.instr[15:0]};
    case (op)
      6'h00: begin
        id_dec.dest = rd;
        id_dec.ctrl.reg_write = 1'b1;
        case (funct)
          6'h20:   id_dec.ctrl.alu_op = ALU_ADD;
          6'h22:   id_dec.ctrl.alu_op = ALU_SUB;
          6'h24:   id_dec.ctrl.alu_op = ALU_AND;
          6'h25:   id_dec.ctrl.alu_op = ALU_OR;
          6'h2A:   id_dec.ctrl.alu_op = ALU_SLT;
          default: begin
            id_dec.ctrl.reg_write = 1'b0;
            id_dec.dest           = 5'd0;
          end
        endcase
      end
      6'h08: begin
        id_dec.dest = rt;
        id_dec.ctrl.reg_write = 1'b1;
        id_dec.ctrl.alu_src   = 1'b1;
        id_dec.ctrl.alu_op    = ALU_ADD;
      end
      6'h23: begin
        id_dec.dest = rt;
        id_dec.ctrl.reg_write = 1'b1;
        id_dec.ctrl.mem_read  = 1'b1;
        id_dec.ctrl.alu_src   = 1'b1;
        id_dec.ctrl.alu_op    = ALU_ADD;
      end
      6'h2B: begin
        id_dec.ctrl.mem_write = 1'b1;
        id_dec.ctrl.alu_src   = 1'b1;
        id_dec.ctrl.alu_op    = ALU_ADD;
      end
      6'h04: begin
        id_dec.ctrl.branch = 1'b1;
        id_dec.ctrl.alu_op = ALU_SUB;
      end
      default: ;
    endcase
  end

  logic stall;
  assign stall = id_ex.ctrl.mem_read && (id_ex.rt == rs || id_ex.rt == rt);

  // ---------------- EX ----------------
  logic [31:0] fwd_a, fwd_b, alu_b, alu_y;
  logic        taken;
  logic [7:0]  br_target;

  always_comb begin
    fwd_a = id_ex.a;
    if (ex_mem.reg_write && ex_mem.dest != 5'd0 && ex_mem.dest == id_ex.rs) fwd_a = ex_mem.alu;
    else if (wb_en && mem_wb.dest == id_ex.rs)                              fwd_a = wb_data;
    fwd_b = id_ex.b;
    if (ex_mem.reg_write && ex_mem.dest != 5'd0 && ex_mem.dest == id_ex.rt) fwd_b = ex_mem.alu;
    else if (wb_en && mem_wb.dest == id_ex.rt)                              fwd_b = wb_data;
  end

  assign alu_b = id_ex.ctrl.alu_src ? id_ex.imm : fwd_b;

  always_comb begin
    alu_y = '0;
    case (id_ex.ctrl.alu_op)
      ALU_ADD: alu_y = fwd_a + alu_b;
      ALU_SUB: alu_y = fwd_a - alu_b;
      ALU_AND: alu_y = fwd_a & alu_b;
      ALU_OR:  alu_y = fwd_a | alu_b;
      ALU_SLT: alu_y = {31'd0, $signed(fwd_a) < $signed(alu_b)};
      default: alu_y = '0;
    endcase
  end

  assign taken     = id_ex.ctrl.branch && (fwd_a == fwd_b);
  assign br_target = id_ex.pc + 8'd4 + {id_ex.imm[5:0], 2'b00};

  // ---------------- pipeline state ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      pc     <= '0;
      if_id  <= '0;
      id_ex  <= '0;
      ex_mem <= '0;
      mem_wb <= '0;
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else if (pc_enable) begin
      if (taken) begin
        pc    <= br_target;
        if_id <= '0;
        id_ex <= '0;
      end else if (stall) begin
        id_ex <= '0;
      end else begin
        pc    <= pc + 8'd4;
        if_id <= '{pc: pc, instr: fetch_instr};
        id_ex <= id_dec;
      end
      ex_mem.reg_write <= id_ex.ctrl.reg_write;
      ex_mem.mem_read  <= id_ex.ctrl.mem_read;
      ex_mem.mem_write <= id_ex.ctrl.mem_write;
      ex_mem.dest      <= id_ex.dest;
      ex_mem.alu       <= alu_y;
      ex_mem.store     <= fwd_b;
      mem_wb.reg_write <= ex_mem.reg_write;
      mem_wb.mem_read  <= ex_mem.mem_read;
      mem_wb.dest      <= ex_mem.dest;
      mem_wb.alu       <= ex_mem.alu;
      mem_wb.mem_data  <= ex_mem.mem_read ? dmem[ex_mem.alu[7:2]] : '0;
      if (wb_en) rf[mem_wb.dest] <= wb_data;
    end
  end

  always_ff @(posedge clk)
    if (!rst && pc_enable && ex_mem.mem_write) dmem[ex_mem.alu[7:2]] <= ex_mem.store;

  assign pc_output  = {24'd0, pc};
  assign ALU_Result = ex_mem.alu;
  assign Mem_out    = mem_wb.mem_data;

  logic unused_bits;
  assign unused_bits = ^{write_address[31:8], shamt};

endmodule

// File: tb/tb_mips_pipeline_processor.sv
// Directed bench: loads a small program, steps the core edge by edge and
// compares PC / ALU_Result / Mem_out against hand-derived values.
module tb_mips_pipeline_processor;
  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  write_data;
  logic [31:0] write_address;
  logic        We;
  logic        pc_enable;
  logic [31:0] pc_output, ALU_Result, Mem_out;

  int n_cmp = 0;
  int n_err = 0;

  mips_pipeline_processor dut (
    .clk(clk), .rst(rst), .write_data(write_data), .write_address(write_address),
    .We(We), .pc_enable(pc_enable), .pc_output(pc_output),
    .ALU_Result(ALU_Result), .Mem_out(Mem_out)
  );

  always #5 clk = ~clk;

  logic [31:0] prog [16] = '{
    32'h20010005, // 0  addi $1,$0,5
    32'h20020007, // 4  addi $2,$0,7
    32'h00221820, // 8  add  $3,$1,$2
    32'hAC030000, // 12 sw   $3,0($0)
    32'h8C040000, // 16 lw   $4,0($0)
    32'h00842820, // 20 add  $5,$4,$4
    32'h10000001, // 24 beq  $0,$0,+1
    32'h20080055, // 28 addi $8,$0,0x55 (skipped)
    32'h00223022, // 32 sub  $6,$1,$2
    32'h0022382A, // 36 slt  $7,$1,$2
    32'h00C74820, // 40 add  $9,$6,$7
    32'h00C35020, // 44 add  $10,$6,$3 (regfile write-through)
    32'h0, 32'h0, 32'h0, 32'h0
  };

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
      else begin
        n_err++;
        $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
  endtask

  task automatic chk3(input string tag, input logic [31:0] pc_e, input logic [31:0] alu_e,
                      input logic [31:0] mem_e);
    chk({tag, ".pc"},  pc_output,  pc_e);
    chk({tag, ".alu"}, ALU_Result, alu_e);
    chk({tag, ".mem"}, Mem_out,    mem_e);
  endtask

  initial begin
    rst = 1'b1; We = 1'b0; pc_enable = 1'b0; write_data = '0; write_address = '0;
    tick();
    chk3("reset", 32'd0, 32'd0, 32'd0);

    rst = 1'b0;
    for (int w = 0; w < 16; w++) begin
      for (int j = 0; j < 4; j++) begin
        logic [31:0] word;
        word          = prog[w];
        We            = 1'b1;
        write_address = 32'(4 * w + j);
        write_data    = word[31 - 8 * j -: 8];
        tick();
      end
    end
    We = 1'b0;
    chk("load.pc_hold", pc_output, 32'd0);

    pc_enable = 1'b1;
    tick(); chk("e1.pc", pc_output, 32'd4);
    tick(); chk("e2.pc", pc_output, 32'd8);
    tick(); chk("e3.pc", pc_output, 32'd12); chk("e3.addi1", ALU_Result, 32'd5);
    tick(); chk("e4.pc", pc_output, 32'd16); chk("e4.addi2", ALU_Result, 32'd7);
    tick(); chk("e5.pc", pc_output, 32'd20); chk("e5.add_fwd", ALU_Result, 32'd12);
    tick(); chk("e6.pc", pc_output, 32'd24); chk("e6.sw_addr", ALU_Result, 32'd0);
    tick(); chk("e7.pc_stall", pc_output, 32'd24); chk("e7.lw_addr", ALU_Result, 32'd0);
    tick(); chk("e8.pc", pc_output, 32'd28); chk("e8.bubble", ALU_Result, 32'd0);
            chk("e8.lw_data", Mem_out, 32'd12);
    tick(); chk("e9.pc", pc_output, 32'd32); chk("e9.load_use", ALU_Result, 32'd24);
    tick(); chk("e10.pc_br", pc_output, 32'd32); chk("e10.beq", ALU_Result, 32'd0);
    tick(); chk("e11.pc", pc_output, 32'd36); chk("e11.flush1", ALU_Result, 32'd0);
    tick(); chk("e12.pc", pc_output, 32'd40); chk("e12.flush2", ALU_Result, 32'd0);
    tick(); chk3("e13.sub", 32'd44, 32'hFFFFFFFE, 32'd0);

    pc_enable = 1'b0;
    for (int f = 0; f < 3; f++) begin
      tick();
      chk3("freeze", 32'd44, 32'hFFFFFFFE, 32'd0);
    end

    pc_enable = 1'b1;
    tick(); chk("e14.pc", pc_output, 32'd48); chk("e14.slt", ALU_Result, 32'd1);
    tick(); chk("e15.pc", pc_output, 32'd52); chk("e15.add_fwd2", ALU_Result, 32'hFFFFFFFF);
    tick(); chk("e16.pc", pc_output, 32'd56); chk("e16.wt_bypass", ALU_Result, 32'd10);

    rst = 1'b1;
    tick();
    chk3("midrst", 32'd0, 32'd0, 32'd0);
    rst = 1'b0;
    tick(); chk("r1.pc", pc_output, 32'd4); chk("r1.alu", ALU_Result, 32'd0);
    tick(); chk("r2.pc", pc_output, 32'd8); chk("r2.alu", ALU_Result, 32'd0);
    tick(); chk("r3.pc", pc_output, 32'd12); chk("r3.addi1", ALU_Result, 32'd5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
